// File: rtl/int_vect_pkg.sv
// Shared definitions for the interrupt vector controller: FSM encoding,
// vector offset and an index-width helper.
package int_vect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACK   = 2'd2,
        GUARD = 2'd3
    } int_vect_state_e;

    // Vector 0 is the reset vector, so request lines start at 1.
    localparam int unsigned VECT_BASE = 1;

    // Index width for n request lines (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_vect_ctrl_if.sv
// CPU-side interrupt handshake: request + vector to the core, accept pulse back.
interface int_vect_ctrl_if #(
    parameter int unsigned VECT_W = 5
);
    logic              cpu_int_req_o;
    logic [VECT_W-1:0] cpu_vect_o;
    logic              cpu_int_ack_i;

    modport master (
        output cpu_int_req_o,
        output cpu_vect_o,
        input  cpu_int_ack_i
    );

    modport slave (
        input  cpu_int_req_o,
        input  cpu_vect_o,
        output cpu_int_ack_i
    );
endinterface

// File: rtl/int_vect_prio_enc.sv
// Combinational lowest-set-bit priority encoder; bit 0 has top priority.
module int_vect_prio_enc
    import int_vect_pkg::*;
#(
    parameter  int unsigned NUM_IRQ = 8,
    localparam int unsigned IDX_W   = idx_w(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic [IDX_W-1:0]   idx_c_o,
    output logic               valid_c_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_c_o   = '0;
        valid_c_o = |req_i;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_c_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_vect_ctrl.sv
// Interrupt vector controller: picks the highest-priority peripheral request,
// presents vector idx+1 to the CPU and returns a one-cycle ack to the winner.
// Optional build macro INT_VECT_MASK_EN adds a per-line enable irq_mask_i.
module int_vect_ctrl
    import int_vect_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned VECT_W  = 5
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    input  logic               gie_i,
`ifdef INT_VECT_MASK_EN
    input  logic [NUM_IRQ-1:0] irq_mask_i,
`endif
    int_vect_ctrl_if.master    cpu_if
);

    localparam int unsigned IDX_W = idx_w(NUM_IRQ);

    // Every line plus the reset vector must fit in the vector field.
    if (NUM_IRQ >= (32'd1 << VECT_W)) begin : g_param_check
        $error("int_vect_ctrl: NUM_IRQ must be smaller than 2**VECT_W");
    end

    int_vect_state_e    state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               req_q;
    logic [VECT_W-1:0]  vect_q;
    logic [NUM_IRQ-1:0] ack_q;

    logic [NUM_IRQ-1:0] eff_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               win_valid_c;
    logic               withdraw_c;

    // Effective request set after optional per-line masking.
`ifdef INT_VECT_MASK_EN
    assign eff_c = irq_i & irq_mask_i;
`else
    assign eff_c = irq_i;
`endif

    int_vect_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req_i     (eff_c),
        .idx_c_o   (win_idx_c),
        .valid_c_o (win_valid_c)
    );

    // Latched source dropped its request (or was masked) or interrupts got disabled.
    assign withdraw_c = !eff_c[idx_q] || !gie_i;

    // Handshake FSM with registered request, vector and ack outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            req_q   <= 1'b0;
            vect_q  <= '0;
            ack_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gie_i && win_valid_c) begin
                        idx_q   <= win_idx_c;
                        vect_q  <= VECT_W'(32'(win_idx_c) + VECT_BASE);
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // CPU acceptance takes precedence over a same-cycle withdrawal.
                    if (cpu_if.cpu_int_ack_i) begin
                        req_q   <= 1'b0;
                        ack_q   <= NUM_IRQ'(1) << idx_q;
                        state_q <= ACK;
                    end else if (withdraw_c) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ACK: begin
                    ack_q   <= '0;
                    state_q <= GUARD;
                end
                GUARD: begin
                    // Dead cycle: the acked source clears its level before re-sampling.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq_ack_o         = ack_q;
    assign cpu_if.cpu_int_req_o = req_q;
    assign cpu_if.cpu_vect_o    = vect_q;

endmodule

// File: tb/tb_int_vect_ctrl.sv
// Bench for int_vect_ctrl: directed scenarios then random traffic, with a
// transaction-level reference model feeding a cycle-stamped scoreboard.
module tb_int_vect_ctrl;

    localparam int unsigned NUM_IRQ = 8;
    localparam int unsigned VECT_W  = 5;

    localparam int EV_REQ  = 1;
    localparam int EV_ACK  = 2;
    localparam int EV_DROP = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_ack;
    logic               gie;
    logic [NUM_IRQ-1:0] mask;

    int_vect_ctrl_if #(.VECT_W(VECT_W)) cpu_if();

    int_vect_ctrl #(
        .NUM_IRQ (NUM_IRQ),
        .VECT_W  (VECT_W)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .irq_i      (irq),
        .irq_ack_o  (irq_ack),
        .gie_i      (gie),
`ifdef INT_VECT_MASK_EN
        .irq_mask_i (mask),
`endif
        .cpu_if     (cpu_if)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    ev_t exp_q[$];

    // ---------------- reference model (transaction level) ----------------
    bit  m_serving = 0;
    int  m_idx     = 0;
    int  m_cool    = 0;

    function automatic logic [NUM_IRQ-1:0] model_eff();
`ifdef INT_VECT_MASK_EN
        return irq & mask;
`else
        return irq;
`endif
    endfunction

    function automatic void push(input int kind, input logic [31:0] val);
        ev_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    // At each edge: a pending request ends by CPU accept (ack, then the line is
    // blocked for two more edges) or by withdrawal; otherwise the lowest
    // enabled line wins when gie is set.
    always @(posedge clk) begin
        logic [NUM_IRQ-1:0] e;
        logic [NUM_IRQ-1:0] lowbit;
        cyc++;
        if (!rst_n) begin
            m_serving = 0;
            m_cool    = 0;
        end else begin
            e = model_eff();
            if (m_serving) begin
                if (cpu_if.cpu_int_ack_i) begin
                    push(EV_ACK, 32'(1) << m_idx);
                    m_serving = 0;
                    m_cool    = 2;
                end else if (!e[m_idx] || !gie) begin
                    push(EV_DROP, 32'd0);
                    m_serving = 0;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (gie && e != '0) begin
                lowbit = e & (~e + NUM_IRQ'(1));
                m_idx  = $clog2(lowbit);
                push(EV_REQ, 32'(m_idx + 1));
                m_serving = 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          prev_req  = 0;
    logic [31:0] held_vect = '0;

    always @(negedge clk) begin
        int          obs_kind;
        logic [31:0] obs_val;
        bit          has_exp;
        ev_t         ex;
        if (!rst_n) begin
            exp_q.delete();
            prev_req = 0;
            total++;
            if (irq_ack != '0 || cpu_if.cpu_int_req_o || cpu_if.cpu_vect_o != '0) begin
                bad++;
                $display("FAIL reset_outputs: ack=%h req=%b vect=%0d, required all 0",
                         irq_ack, cpu_if.cpu_int_req_o, cpu_if.cpu_vect_o);
            end
        end else begin
            obs_kind = 0;
            obs_val  = '0;
            if (irq_ack != '0) begin
                obs_kind = EV_ACK;
                obs_val  = 32'(irq_ack);
            end else if (prev_req && !cpu_if.cpu_int_req_o) begin
                obs_kind = EV_DROP;
            end else if (!prev_req && cpu_if.cpu_int_req_o) begin
                obs_kind  = EV_REQ;
                obs_val   = 32'(cpu_if.cpu_vect_o);
                held_vect = obs_val;
            end
            has_exp = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            if (has_exp || obs_kind != 0) begin
                total++;
                if (!has_exp) begin
                    bad++;
                    $display("FAIL event@%0d: got kind=%0d val=%0h, required no event",
                             cyc, obs_kind, obs_val);
                end else begin
                    ex = exp_q.pop_front();
                    if (ex.kind != obs_kind || ex.val != obs_val) begin
                        bad++;
                        $display("FAIL event@%0d: got kind=%0d val=%0h, required kind=%0d val=%0h",
                                 cyc, obs_kind, obs_val, ex.kind, ex.val);
                    end
                end
            end
            if (prev_req && cpu_if.cpu_int_req_o) begin
                total++;
                if (32'(cpu_if.cpu_vect_o) != held_vect) begin
                    bad++;
                    $display("FAIL vect_stable@%0d: got %0d, required %0d",
                             cyc, cpu_if.cpu_vect_o, held_vect);
                end
            end
            prev_req = cpu_if.cpu_int_req_o;
        end
    end

    // ---------------- stimulus ----------------
    // One cycle: sources drop acked lines, CPU accept returns to 0.
    task automatic tick();
        @(negedge clk);
        irq = irq & ~irq_ack;
        cpu_if.cpu_int_ack_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!cpu_if.cpu_int_req_o && n < max) begin
            tick();
            n++;
        end
        total++;
        if (!cpu_if.cpu_int_req_o) begin
            bad++;
            $display("FAIL wait_req: req=0 after %0d cycles, required 1", max);
        end
    endtask

    task automatic serve();
        wait_req(50);
        cpu_if.cpu_int_ack_i = 1'b1;
        tick();
    endtask

    task automatic rand_cycle();
        tick();
        if (cpu_if.cpu_int_req_o && $urandom_range(3) == 0) cpu_if.cpu_int_ack_i = 1'b1;
        else if ($urandom_range(49) == 0) cpu_if.cpu_int_ack_i = 1'b1;
        if ($urandom_range(5) == 0)  irq[$urandom_range(NUM_IRQ - 1)] = 1'b1;
        if ($urandom_range(39) == 0) irq[$urandom_range(NUM_IRQ - 1)] = 1'b0;
        if (gie && $urandom_range(59) == 0) gie = 1'b0;
        else if (!gie && $urandom_range(7) == 0) gie = 1'b1;
`ifdef INT_VECT_MASK_EN
        if ($urandom_range(19) == 0) mask = NUM_IRQ'($urandom);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        irq   = '0;
        gie   = 1'b0;
        mask  = '1;
        cpu_if.cpu_int_ack_i = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Single request on line 4 -> vector 5, no re-request after ack.
        gie = 1'b1;
        irq = 8'h10;
        serve();
        idle(6);

        // Simultaneous lines 2 and 3: vector 3 first, then vector 4.
        irq = 8'h0C;
        serve();
        serve();
        idle(6);

        // No pre-emption: line 5 pending, line 0 arrives later.
        irq = 8'h20;
        wait_req(50);
        tick();
        irq[0] = 1'b1;
        idle(4);
        cpu_if.cpu_int_ack_i = 1'b1;
        tick();
        serve();
        idle(6);

        // Global disable holds everything off; dropping gie in REQ withdraws.
        gie = 1'b0;
        irq = 8'hFF;
        idle(20);
        gie = 1'b1;
        wait_req(50);
        tick();
        gie = 1'b0;
        idle(4);
        irq = '0;
        gie = 1'b1;
        idle(4);

        // Source withdrawal in REQ: no ack.
        irq = 8'h04;
        wait_req(50);
        tick();
        irq[2] = 1'b0;
        idle(4);

        // Reset during ACK truncates the pulse; the source is served again.
        irq = 8'h04;
        wait_req(50);
        cpu_if.cpu_int_ack_i = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        wait_req(50);
        total++;
        if (cpu_if.cpu_vect_o != VECT_W'(3)) begin
            bad++;
            $display("FAIL reserve_after_reset: vect=%0d, required 3", cpu_if.cpu_vect_o);
        end
        cpu_if.cpu_int_ack_i = 1'b1;
        tick();
        idle(4);

        // Lines 0 and 1; line 0 masked off when masking is built in.
`ifdef INT_VECT_MASK_EN
        mask = 8'hFE;
`endif
        irq = 8'h03;
        serve();
`ifdef INT_VECT_MASK_EN
        mask = '1;
`endif
        serve();
        idle(6);

        // Random traffic.
        for (int c = 0; c < 3000; c++) rand_cycle();

        // Drain: no new requests, CPU accepts whatever is pending.
        irq = '0;
        gie = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (cpu_if.cpu_int_req_o) cpu_if.cpu_int_ack_i = 1'b1;
        end
        idle(2);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
